// File: rtl/uio_sum_if.sv
// Bundles the operand-byte input stream and the uio-pin transmit handshake of uio_sum_tx.
// The master side is the accumulator/transmitter; the slave side is its environment.
interface uio_sum_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic [7:0] tx_oe;
    logic       busy;

    modport master (
        input  in_data, in_valid, in_last, tx_ack,
        output in_ready, tx_data, tx_valid, tx_oe, busy
    );

    modport slave (
        output in_data, in_valid, in_last, tx_ack,
        input  in_ready, tx_data, tx_valid, tx_oe, busy
    );
endinterface

// File: rtl/uio_sum_tx.sv
// Counts and sums operand bytes per frame, then sends {count, sum_lo, sum_hi} over the
// uio pins using a four-phase req/ack handshake, releasing the bus when idle.
module uio_sum_tx #(
    parameter int ACK_SYNC = 2,
    parameter int SUM_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    uio_sum_if.master  bus
);

    typedef enum logic [1:0] {
        ACC      = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [SUM_W-1:0] sum, sum_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [SUM_W-1:0] frame_sum, frame_sum_nxt;
    logic [7:0]       frame_cnt, frame_cnt_nxt;
    logic [7:0]       tx_data_q, tx_data_nxt;
    logic             ack_s;

    // tx_ack comes from another clock domain; ACK_SYNC=0 trusts it to be synchronous already
    generate
        if (ACK_SYNC == 0) begin : g_no_sync
            assign ack_s = bus.tx_ack;
        end else begin : g_sync
            logic [ACK_SYNC-1:0] sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '0;
                end else begin
                    sync <= (sync << 1) | ACK_SYNC'(bus.tx_ack);
                end
            end
            assign ack_s = sync[ACK_SYNC-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            idx       <= '0;
            sum       <= '0;
            cnt       <= '0;
            frame_sum <= '0;
            frame_cnt <= '0;
            tx_data_q <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            sum       <= sum_nxt;
            cnt       <= cnt_nxt;
            frame_sum <= frame_sum_nxt;
            frame_cnt <= frame_cnt_nxt;
            tx_data_q <= tx_data_nxt;
        end
    end

    // tx_data is loaded only on entering REQ, so it cannot move while tx_valid is high
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        sum_nxt       = sum;
        cnt_nxt       = cnt;
        frame_sum_nxt = frame_sum;
        frame_cnt_nxt = frame_cnt;
        tx_data_nxt   = tx_data_q;

        case (state)
            ACC: begin
                if (bus.in_valid) begin
                    if (bus.in_last) begin
                        frame_cnt_nxt = cnt + 8'd1;
                        frame_sum_nxt = sum + SUM_W'(bus.in_data);
                        sum_nxt       = '0;
                        cnt_nxt       = '0;
                        idx_nxt       = 2'd0;
                        tx_data_nxt   = cnt + 8'd1;
                        state_nxt     = REQ;
                    end else begin
                        sum_nxt = sum + SUM_W'(bus.in_data);
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    if (idx == 2'd2) begin
                        idx_nxt     = 2'd0;
                        tx_data_nxt = 8'h00;
                        state_nxt   = ACC;
                    end else begin
                        idx_nxt     = idx + 2'd1;
                        tx_data_nxt = (idx == 2'd0) ? frame_sum[7:0] : frame_sum[15:8];
                        state_nxt   = REQ;
                    end
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    assign bus.in_ready = (state == ACC);
    assign bus.tx_valid = (state == REQ);
    assign bus.busy     = (state != ACC);
    assign bus.tx_oe    = (state != ACC) ? 8'hFF : 8'h00;
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uio_sum_tx.sv
// Directed self-checking bench for uio_sum_tx: dut0 runs with ACK_SYNC=0, dut2 with ACK_SYNC=2.
// A receiver task plays the four-phase protocol and checks bytes, stability and edge latencies.
module tb_uio_sum_tx;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    uio_sum_if if0 ();
    uio_sum_if if2 ();

    uio_sum_tx #(.ACK_SYNC(0), .SUM_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    uio_sum_tx #(.ACK_SYNC(2), .SUM_W(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic g_valid(bit s);
        return s ? if2.tx_valid : if0.tx_valid;
    endfunction

    function automatic logic [7:0] g_data(bit s);
        return s ? if2.tx_data : if0.tx_data;
    endfunction

    function automatic logic g_busy(bit s);
        return s ? if2.busy : if0.busy;
    endfunction

    function automatic logic [7:0] g_oe(bit s);
        return s ? if2.tx_oe : if0.tx_oe;
    endfunction

    function automatic logic g_ready(bit s);
        return s ? if2.in_ready : if0.in_ready;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit s, input bit v, input logic [7:0] d, input bit l);
        if (s) begin
            if2.in_valid = v; if2.in_data = d; if2.in_last = l;
        end else begin
            if0.in_valid = v; if0.in_data = d; if0.in_last = l;
        end
    endtask

    task automatic set_ack(input bit s, input bit a);
        if (s) if2.tx_ack = a;
        else    if0.tx_ack = a;
    endtask

    // Receive one byte: ack dly cycles after req, keep ack high hold cycles total (and until
    // req drops), then release; k is the synchronizer depth used for latency expectations.
    task automatic recv_byte(input bit s, input int k, input int dly, input int hold,
                             input logic [7:0] exp, input bit last, input string tag);
        int n;
        bit stable;
        n = 0;
        while (g_valid(s) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " req"}, 32'(g_valid(s)), 32'd1);
        check_output({tag, " data"}, 32'(g_data(s)), 32'(exp));
        check_output({tag, " oe"}, 32'(g_oe(s)), 32'hFF);
        stable = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (g_valid(s) !== 1'b1 || g_data(s) !== exp) stable = 1'b0;
        end
        check_output({tag, " stable"}, 32'(stable), 32'd1);
        set_ack(s, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (g_valid(s) === 1'b1 && n < 50);
        check_output({tag, " ack_to_fall"}, 32'(n), 32'(k + 1));
        check_output({tag, " data_hold"}, 32'(g_data(s)), 32'(exp));
        if (hold > n) begin
            repeat (hold - n) @(negedge clk);
            check_output({tag, " stall"}, 32'(g_valid(s)), 32'd0);
        end
        set_ack(s, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (g_valid(s) !== 1'b1 && g_busy(s) === 1'b1 && n < 50);
        check_output({tag, " release_to_next"}, 32'(n), 32'(k + 1));
        if (last) begin
            check_output({tag, " idle_oe"}, 32'(g_oe(s)), 32'h00);
            check_output({tag, " idle_valid"}, 32'(g_valid(s)), 32'd0);
            check_output({tag, " idle_data"}, 32'(g_data(s)), 32'h00);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        apply_stimulus(0, 0, 8'h00, 0);
        apply_stimulus(1, 0, 8'h00, 0);
        set_ack(0, 0);
        set_ack(1, 0);
        repeat (3) @(negedge clk);

        // Reset state
        check_output("rst ready", 32'(g_ready(1)), 32'd1);
        check_output("rst valid", 32'(g_valid(1)), 32'd0);
        check_output("rst oe", 32'(g_oe(1)), 32'h00);
        check_output("rst busy", 32'(g_busy(1)), 32'd0);
        check_output("rst data", 32'(g_data(1)), 32'h00);
        check_output("rst oe0", 32'(g_oe(0)), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Frame 0x0A 0x14 0x1E on the unsynchronized instance
        apply_stimulus(0, 1, 8'h0A, 0); @(negedge clk);
        apply_stimulus(0, 1, 8'h14, 0); @(negedge clk);
        apply_stimulus(0, 1, 8'h1E, 1); @(negedge clk);
        apply_stimulus(0, 0, 8'h00, 0);
        check_output("t1 first_latency", 32'(g_valid(0)), 32'd1);
        check_output("t1 busy", 32'(g_busy(0)), 32'd1);
        recv_byte(0, 0, 2, 1, 8'h03, 0, "t1 b0");
        recv_byte(0, 0, 2, 1, 8'h3C, 0, "t1 b1");
        recv_byte(0, 0, 2, 1, 8'h00, 1, "t1 b2");

        // 257 beats of 0xFF wrap count to 1 and sum to 0xFFFF
        for (int i = 0; i < 257; i++) begin
            apply_stimulus(1, 1, 8'hFF, (i == 256));
            @(negedge clk);
        end
        apply_stimulus(1, 0, 8'h00, 0);
        check_output("t2 first_latency", 32'(g_valid(1)), 32'd1);
        recv_byte(1, 2, 1, 1, 8'h01, 0, "t2 b0");
        recv_byte(1, 2, 1, 1, 8'hFF, 0, "t2 b1");
        recv_byte(1, 2, 1, 1, 8'hFF, 1, "t2 b2");
        apply_stimulus(1, 1, 8'h05, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        recv_byte(1, 2, 1, 1, 8'h01, 0, "t2b b0");
        recv_byte(1, 2, 1, 1, 8'h05, 0, "t2b b1");
        recv_byte(1, 2, 1, 1, 8'h00, 1, "t2b b2");

        // Ack held 10 cycles per byte through the synchronizer
        apply_stimulus(1, 1, 8'h10, 0); @(negedge clk);
        apply_stimulus(1, 1, 8'h20, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        recv_byte(1, 2, 1, 10, 8'h02, 0, "t3 b0");
        recv_byte(1, 2, 1, 10, 8'h30, 0, "t3 b1");
        recv_byte(1, 2, 1, 10, 8'h00, 1, "t3 b2");
        repeat (5) @(negedge clk);
        check_output("t3 no_extra_byte", 32'(g_valid(1)), 32'd0);

        // in_valid held with 0x77 during the transfer is ignored until back in ACC
        apply_stimulus(1, 1, 8'h01, 1); @(negedge clk);
        apply_stimulus(1, 1, 8'h77, 0);
        check_output("t4 ready_low", 32'(g_ready(1)), 32'd0);
        recv_byte(1, 2, 1, 1, 8'h01, 0, "t4 b0");
        check_output("t4 ready_low_mid", 32'(g_ready(1)), 32'd0);
        recv_byte(1, 2, 1, 1, 8'h01, 0, "t4 b1");
        recv_byte(1, 2, 1, 1, 8'h00, 1, "t4 b2");
        check_output("t4 ready_back", 32'(g_ready(1)), 32'd1);
        @(negedge clk);
        apply_stimulus(1, 1, 8'h77, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        recv_byte(1, 2, 1, 1, 8'h02, 0, "t4b b0");
        recv_byte(1, 2, 1, 1, 8'hEE, 0, "t4b b1");
        recv_byte(1, 2, 1, 1, 8'h00, 1, "t4b b2");

        // Reset pulse while in WAIT_LOW(1) aborts the frame
        apply_stimulus(1, 1, 8'h09, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        recv_byte(1, 2, 1, 1, 8'h01, 0, "t5 b0");
        check_output("t5 b1 data", 32'(g_data(1)), 32'h09);
        set_ack(1, 1);
        for (int i = 0; i < 50 && g_valid(1) === 1'b1; i++) @(negedge clk);
        check_output("t5 in_wait_low", 32'(g_busy(1)), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_ack(1, 0);
        check_output("t5 oe", 32'(g_oe(1)), 32'h00);
        check_output("t5 valid", 32'(g_valid(1)), 32'd0);
        check_output("t5 busy", 32'(g_busy(1)), 32'd0);
        check_output("t5 ready", 32'(g_ready(1)), 32'd1);
        apply_stimulus(1, 1, 8'h02, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        recv_byte(1, 2, 1, 1, 8'h01, 0, "t5b b0");
        recv_byte(1, 2, 1, 1, 8'h02, 0, "t5b b1");
        recv_byte(1, 2, 1, 1, 8'h00, 1, "t5b b2");

        // in_last without in_valid does nothing, then a slow receiver on frame 0x80
        apply_stimulus(1, 0, 8'h55, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        check_output("t6 last_no_valid", 32'(g_busy(1)), 32'd0);
        apply_stimulus(1, 1, 8'h80, 1); @(negedge clk);
        apply_stimulus(1, 0, 8'h00, 0);
        recv_byte(1, 2, 20, 1, 8'h01, 0, "t6 b0");
        recv_byte(1, 2, 1, 1, 8'h80, 0, "t6 b1");
        recv_byte(1, 2, 1, 1, 8'h00, 1, "t6 b2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
